// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register map, STATUS/CTRL bit
// positions and the transmit sequencer state encoding.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_IDLE  = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_OVF   = 4;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAITB = 2'd2,
    TX_WAITD = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a show-ahead head word; a pop frees a slot for a push in
// the same cycle, so a full FIFO still accepts a write while it is being read.
module uart_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]       count_q, count_d;
  logic              doPush, doPop;

  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != DEPTH_C) || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    if (doPush && !doPop)      count_d = count_q + (AW+1)'(1);
    else if (doPop && !doPush) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which words are valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_ctrl.sv
// CPU-facing UART controller: TX/RX FIFOs, DATA/STATUS/CTRL registers, level IRQ and
// the start/busy handshake sequencer that feeds the external transmitter.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bus_en_i,
  input  logic              bus_we_i,
  input  logic [1:0]        bus_addr_i,
  input  logic [7:0]        bus_wdata_i,
  output logic [7:0]        bus_rdata_o,
  output logic              irq_o,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_busy_i,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e         state_q, state_d;
  logic              waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              txOvf_q, txOvf_d;
  logic              rxOvr_q, rxOvr_d;

  logic              dataWr, dataRd, statusWr, ctrlWr;
  logic              txPop, txFull, txEmpty;
  logic              rxPop, rxFull, rxEmpty;
  logic [DATA_W-1:0] txHead, rxHead;
  logic [CW-1:0]     txCount, rxCount;
  logic [7:0]        statusVec, readMux;

  assign dataWr   = bus_en_i &&  bus_we_i && (bus_addr_i == ADDR_DATA);
  assign dataRd   = bus_en_i && !bus_we_i && (bus_addr_i == ADDR_DATA);
  assign statusWr = bus_en_i &&  bus_we_i && (bus_addr_i == ADDR_STATUS);
  assign ctrlWr   = bus_en_i &&  bus_we_i && (bus_addr_i == ADDR_CTRL);
  assign rxPop    = dataRd && !rxEmpty;

  uart_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_txFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (dataWr),
    .pop_i   (txPop),
    .wdata_i (DATA_W'(bus_wdata_i)),
    .rdata_o (txHead),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .count_o (txCount)
  );

  uart_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rxFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_ready_i),
    .pop_i   (rxPop),
    .wdata_i (rx_data_i),
    .rdata_o (rxHead),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .count_o (rxCount)
  );

  always_comb begin
    statusVec              = '0;
    statusVec[ST_RX_AVAIL] = (rxCount != '0);
    statusVec[ST_TX_FULL]  = txFull;
    statusVec[ST_TX_IDLE]  = (txCount == '0) && (state_q == TX_IDLE) && !tx_busy_i;
    statusVec[ST_RX_OVR]   = rxOvr_q;
    statusVec[ST_TX_OVF]   = txOvf_q;

    readMux = '0;
    case (bus_addr_i)
      ADDR_DATA:   readMux = rxEmpty ? 8'h00 : 8'(rxHead);
      ADDR_STATUS: readMux = statusVec;
      ADDR_CTRL:   readMux = {6'b0, ctrl_q};
      default:     readMux = '0;
    endcase

    rdata_d = (bus_en_i && !bus_we_i) ? readMux : rdata_q;
    ctrl_d  = ctrlWr ? bus_wdata_i[1:0] : ctrl_q;

    // A new overflow in the same cycle as a software clear keeps the flag set.
    txOvf_d = (dataWr && txFull && !txPop) ||
              (txOvf_q && !(statusWr && bus_wdata_i[ST_TX_OVF]));
    rxOvr_d = (rx_ready_i && rxFull && !rxPop) ||
              (rxOvr_q && !(statusWr && bus_wdata_i[ST_RX_OVR]));

    irq_d = (ctrl_q[CTRL_RX_IE] && statusVec[ST_RX_AVAIL]) ||
            (ctrl_q[CTRL_TX_IE] && statusVec[ST_TX_IDLE]) || rxOvr_q || txOvf_q;
  end

  // Transmit sequencer; WAITB retries the start if busy never rises within two cycles.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    txData_d  = txData_q;
    txPop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!txEmpty && !tx_busy_i) begin
          txPop    = 1'b1;
          txData_d = txHead;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        waitCnt_d = 1'b0;
        state_d   = TX_WAITB;
      end
      TX_WAITB: begin
        if (tx_busy_i)      state_d   = TX_WAITD;
        else if (waitCnt_q) state_d   = TX_START;
        else                waitCnt_d = 1'b1;
      end
      TX_WAITD: begin
        if (!tx_busy_i) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= TX_IDLE;
      waitCnt_q <= 1'b0;
      txData_q  <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      ctrl_q    <= '0;
      txOvf_q   <= 1'b0;
      rxOvr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      txData_q  <= txData_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      ctrl_q    <= ctrl_d;
      txOvf_q   <= txOvf_d;
      rxOvr_q   <= rxOvr_d;
    end
  end

  assign bus_rdata_o = rdata_q;
  assign irq_o       = irq_q;
  assign tx_start_o  = (state_q == TX_START);
  assign tx_data_o   = txData_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed-plus-random bench for uart_ctrl with a queue-based model of both FIFOs
// and a simple transmitter that answers tx_start with a fixed-length busy frame.
module tb_uart_ctrl;

  localparam int DEPTH = 16;
  localparam int FRAME = 20;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       bus_en = 1'b0, bus_we = 1'b0;
  logic [1:0] bus_addr = 2'd0;
  logic [7:0] bus_wdata = 8'h00, bus_rdata;
  logic       irq, tx_start, tx_busy = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data, rx_data = 8'h00;

  int   checks = 0, errors = 0;
  int   startCount = 0, doublePulse = 0, busyCnt = 0, base = 0, guard = 0;
  bit   holdBusy = 0, noResponse = 0, prevStart = 0, rxOvrModel = 0;
  logic [7:0] txModel[$], rxModel[$], txSeen[$];
  logic [7:0] rd, b;

  uart_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_en_i    (bus_en),
    .bus_we_i    (bus_we),
    .bus_addr_i  (bus_addr),
    .bus_wdata_i (bus_wdata),
    .bus_rdata_o (bus_rdata),
    .irq_o       (irq),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .rx_ready_i  (rx_ready),
    .rx_data_i   (rx_data)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy rises right after a start pulse and lasts FRAME cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      startCount++;
      txSeen.push_back(tx_data);
      if (prevStart) doublePulse++;
    end
    prevStart = tx_start;
    if (holdBusy) tx_busy = 1'b1;
    else if (tx_start && !noResponse) begin
      tx_busy = 1'b1;
      busyCnt = FRAME;
    end else if (busyCnt > 1) busyCnt--;
    else begin
      busyCnt = 0;
      tx_busy = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic we, input logic [1:0] addr,
                               input logic [7:0] wdata, input logic rxr, input logic [7:0] rxd);
    bus_en = en; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    rx_ready = rxr; rx_data = rxd;
    @(negedge clk);
    bus_en = 1'b0; bus_we = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, addr, d, 1'b0, 8'h00);
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [7:0] d);
    applyStimulus(1'b1, 1'b0, addr, 8'h00, 1'b0, 8'h00);
    d = bus_rdata;
  endtask

  task automatic pushRx(input logic [7:0] v);
    if (rxModel.size() < DEPTH) rxModel.push_back(v);
    else rxOvrModel = 1'b1;
    applyStimulus(1'b0, 1'b0, A_DATA, 8'h00, 1'b1, v);
  endtask

  // DATA read, optionally with a received byte arriving in the same cycle.
  task automatic readRxCheck(input string tag, input bit withPush, input logic [7:0] v);
    logic [7:0] exp;
    exp = (rxModel.size() != 0) ? rxModel[0] : 8'h00;
    if (rxModel.size() != 0) void'(rxModel.pop_front());
    if (withPush) begin
      if (rxModel.size() < DEPTH) rxModel.push_back(v);
      else rxOvrModel = 1'b1;
    end
    applyStimulus(1'b1, 1'b0, A_DATA, 8'h00, withPush, v);
    checkOutput(tag, bus_rdata, exp);
  endtask

  // STATUS expected while the TX side is drained and quiet.
  function automatic logic [7:0] quietStatus();
    return {4'b0, rxOvrModel, 1'b1, 1'b0, rxModel.size() != 0};
  endfunction

  task automatic waitTxIdle(input string tag);
    rd = 8'h00;
    guard = 0;
    while (!rd[2] && guard < 2000) begin
      busRead(A_STATUS, rd);
      guard++;
    end
    checkOutput(tag, {7'b0, rd[2]}, 8'h01);
  endtask

  task automatic checkTxSeen(input string tag);
    checkOutput({tag, " count"}, 8'(txSeen.size()), 8'(txModel.size()));
    for (int i = 0; i < txModel.size() && i < txSeen.size(); i++)
      checkOutput(tag, txSeen[i], txModel[i]);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset irq", {7'b0, irq}, 8'h00);
    checkOutput("reset tx_start", {7'b0, tx_start}, 8'h00);
    checkOutput("reset tx_data", tx_data, 8'h00);
    checkOutput("reset rdata", bus_rdata, 8'h00);
    busRead(A_STATUS, rd);
    checkOutput("reset status", rd, 8'h04);
    busRead(A_CTRL, rd);
    checkOutput("reset ctrl", rd, 8'h00);
    checkOutput("reset irq after reads", {7'b0, irq}, 8'h00);
    checkOutput("no start after reset", 8'(startCount), 8'h00);

    // Three fixed characters followed by random ones with random gaps.
    txSeen.delete();
    txModel = {8'h41, 8'h42, 8'h43};
    base = startCount;
    foreach (txModel[i]) busWrite(A_DATA, txModel[i]);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      txModel.push_back(b);
      busWrite(A_DATA, b);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    waitTxIdle("tx drained");
    checkOutput("tx start pulses", 8'(startCount - base), 8'(txModel.size()));
    checkTxSeen("tx data order");
    busRead(A_STATUS, rd);
    checkOutput("status after tx", rd, 8'h04);

    busWrite(A_CTRL, 8'hFF);
    busRead(A_CTRL, rd);
    checkOutput("ctrl mask", rd, 8'h03);
    checkOutput("irq tx_ie idle", {7'b0, irq}, 8'h01);
    busWrite(A_CTRL, 8'h00);
    busRead(A_STATUS, rd);
    checkOutput("irq ctrl cleared", {7'b0, irq}, 8'h00);

    // Transmitter ignores the start: the controller must keep retrying the same byte.
    txSeen.delete();
    txModel = {8'h77};
    noResponse = 1'b1;
    base = startCount;
    busWrite(A_DATA, 8'h77);
    repeat (12) @(negedge clk);
    checkOutput("retry restarts", 8'(startCount - base >= 2), 8'h01);
    foreach (txSeen[i]) checkOutput("retry data", txSeen[i], 8'h77);
    noResponse = 1'b0;
    waitTxIdle("retry completes");

    // Overflow the TX FIFO while the transmitter is stuck busy.
    holdBusy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) busWrite(A_DATA, 8'($urandom));
    busRead(A_STATUS, rd);
    checkOutput("status tx full+ovf", rd, 8'h12);
    checkOutput("irq tx_ovf", {7'b0, irq}, 8'h01);
    busWrite(A_STATUS, 8'hE7);
    busRead(A_STATUS, rd);
    checkOutput("status ignore other bits", rd, 8'h12);
    busWrite(A_STATUS, 8'h10);
    busRead(A_STATUS, rd);
    checkOutput("status tx_ovf cleared", rd, 8'h02);

    // Reset mid-frame: queued bytes vanish and no start until busy falls.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset rdata", bus_rdata, 8'h00);
    base = startCount;
    repeat (5) @(negedge clk);
    busRead(A_STATUS, rd);
    checkOutput("midreset status busy", rd, 8'h00);
    txSeen.delete();
    txModel.delete();
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      txModel.push_back(b);
      busWrite(A_DATA, b);
    end
    repeat (10) @(negedge clk);
    checkOutput("no start while busy", 8'(startCount - base), 8'h00);
    holdBusy = 1'b0;
    waitTxIdle("post reset drain");
    checkOutput("post reset starts", 8'(startCount - base), 8'h02);
    checkTxSeen("post reset data");

    // Receive path basics.
    pushRx(8'h5A);
    pushRx(8'hA5);
    busRead(A_STATUS, rd);
    checkOutput("rx_avail 1st", {7'b0, rd[0]}, 8'h01);
    readRxCheck("rx read 5A", 1'b0, 8'h00);
    busRead(A_STATUS, rd);
    checkOutput("rx_avail 2nd", {7'b0, rd[0]}, 8'h01);
    readRxCheck("rx read A5", 1'b0, 8'h00);
    busRead(A_STATUS, rd);
    checkOutput("rx_avail empty", {7'b0, rd[0]}, 8'h00);
    readRxCheck("rx read empty", 1'b0, 8'h00);

    // Full RX FIFO: simultaneous push/pop, then overflow and set-beats-clear.
    for (int i = 0; i < DEPTH; i++) pushRx(8'($urandom));
    busRead(A_STATUS, rd);
    checkOutput("rx full status", rd, quietStatus());
    readRxCheck("rx full push+pop", 1'b1, 8'($urandom));
    busRead(A_STATUS, rd);
    checkOutput("rx no ovr on push+pop", rd, quietStatus());
    pushRx(8'($urandom));
    busRead(A_STATUS, rd);
    checkOutput("rx ovr set", rd, quietStatus());
    checkOutput("rx ovr status bit", {7'b0, rd[3]}, 8'h01);
    checkOutput("irq rx_ovr", {7'b0, irq}, 8'h01);
    applyStimulus(1'b1, 1'b1, A_STATUS, 8'h08, 1'b1, 8'($urandom));
    busRead(A_STATUS, rd);
    checkOutput("set wins over clear", {7'b0, rd[3]}, 8'h01);
    busWrite(A_STATUS, 8'h08);
    rxOvrModel = 1'b0;
    busRead(A_STATUS, rd);
    checkOutput("rx ovr cleared", rd, quietStatus());
    for (int i = 0; i < DEPTH; i++) readRxCheck("rx drain", 1'b0, 8'h00);
    readRxCheck("rx drained empty", 1'b0, 8'h00);

    pushRx(8'h3C);
    busWrite(A_CTRL, 8'h01);
    busRead(A_STATUS, rd);
    checkOutput("irq rx_ie", {7'b0, irq}, 8'h01);
    busWrite(A_CTRL, 8'h00);
    readRxCheck("rx_ie byte", 1'b0, 8'h00);

    // Random interleaving of received bytes and DATA reads.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) readRxCheck("rx random read", $urandom_range(0, 2) != 0, 8'($urandom));
      else if ($urandom_range(0, 2) != 0) pushRx(8'($urandom));
      else @(negedge clk);
      if (i % 50 == 49) begin
        busRead(A_STATUS, rd);
        checkOutput("rx random status", rd, quietStatus());
        if (rxOvrModel) begin
          busWrite(A_STATUS, 8'h08);
          rxOvrModel = 1'b0;
        end
      end
    end

    checkOutput("single-cycle start pulses", 8'(doublePulse), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
